// File: rtl/mult4_pp_compress_pipe.sv
// 4x4 multiplier front end: partial-product generation (Baugh-Wooley when signed)
// and a full/half-adder compressor tree, pipelined behind a valid/ready handshake.
module mult4_pp_compress_pipe #(
  parameter int SIGNED = 1,
  parameter int STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] in_a,
  input  logic [3:0] in_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [6:0] out_row_a,
  output logic [6:0] out_row_b,
  output logic       out_c7
);

  localparam logic CONST_BIT = (SIGNED != 0);

  // pp[4*i+j] = a[j] & b[i], weight 2^(i+j); sign-row/column cross terms inverted
  function automatic logic [15:0] gen_pp(input logic [3:0] a, input logic [3:0] b);
    logic [15:0] pp;
    pp = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        pp[4*i+j] = a[j] & b[i];
        if ((SIGNED != 0) && ((i == 3) != (j == 3))) pp[4*i+j] = ~pp[4*i+j];
      end
    end
    return pp;
  endfunction

  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Returns {c7, row_b, row_a}. Baugh-Wooley constants enter as ordinary bits
  // at columns 4 and 7; column 7 carries nothing in, so it is just the constant.
  function automatic logic [14:0] compress(input logic [15:0] pp);
    logic [1:0] f2, f3a, h3b, f4a, f4b, f5a;
    logic [6:0] ra, rb;
    f2  = fa(pp[2], pp[5], pp[8]);
    f3a = fa(pp[3], pp[6], pp[9]);
    h3b = ha(pp[12], f2[1]);
    f4a = fa(pp[7], pp[10], pp[13]);
    f4b = fa(CONST_BIT, f3a[1], h3b[1]);
    f5a = fa(pp[11], pp[14], f4a[1]);
    ra  = {pp[15], f5a[0], f4a[0], f3a[0], f2[0], pp[1], pp[0]};
    rb  = {f5a[1], f4b[1], f4b[0], h3b[0], 1'b0, pp[4], 1'b0};
    return {CONST_BIT, rb, ra};
  endfunction

  if (STAGES == 1) begin : g_s1
    logic        v_q, v_d;
    logic [14:0] res_q, res_d;
    logic        adv;

    always_comb begin
      adv   = !v_q || out_ready;
      v_d   = v_q;
      res_d = res_q;
      if (adv) begin
        v_d = in_valid;
        if (in_valid) res_d = compress(gen_pp(in_a, in_b));
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        res_q <= '0;
      end else begin
        v_q   <= v_d;
        res_q <= res_d;
      end
    end

    assign in_ready  = adv;
    assign out_valid = v_q;
    assign out_row_a = res_q[6:0];
    assign out_row_b = res_q[13:7];
    assign out_c7    = res_q[14];
  end else if (STAGES == 2) begin : g_s2
    logic        v1_q, v1_d, v2_q, v2_d;
    logic [15:0] pp_q, pp_d;
    logic [14:0] res_q, res_d;
    logic        adv1, adv2;

    always_comb begin
      adv2  = !v2_q || out_ready;
      adv1  = !v1_q || adv2;
      v1_d  = v1_q;
      v2_d  = v2_q;
      pp_d  = pp_q;
      res_d = res_q;
      if (adv2) begin
        v2_d = v1_q;
        if (v1_q) res_d = compress(pp_q);
      end
      if (adv1) begin
        v1_d = in_valid;
        if (in_valid) pp_d = gen_pp(in_a, in_b);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v1_q  <= 1'b0;
        v2_q  <= 1'b0;
        pp_q  <= '0;
        res_q <= '0;
      end else begin
        v1_q  <= v1_d;
        v2_q  <= v2_d;
        pp_q  <= pp_d;
        res_q <= res_d;
      end
    end

    assign in_ready  = adv1;
    assign out_valid = v2_q;
    assign out_row_a = res_q[6:0];
    assign out_row_b = res_q[13:7];
    assign out_c7    = res_q[14];
  end else begin : g_bad_stages
    $error("mult4_pp_compress_pipe: STAGES must be 1 or 2");
  end

endmodule

// File: tb/tb_mult4_pp_compress_pipe.sv
// Bench for mult4_pp_compress_pipe: four configurations (signed/unsigned x 1/2 stages)
// checked against plain integer multiplication and a FIFO ordering model.
module tb_mult4_pp_compress_pipe;

  logic       clk;
  logic       rst_n;
  logic [3:0] in_valid, in_ready, out_valid, out_ready, c7;
  logic [3:0] in_a [4];
  logic [3:0] in_b [4];
  logic [6:0] row_a [4];
  logic [6:0] row_b [4];

  int checks = 0;
  int errors = 0;

  // idx 0: signed/2 stages, 1: unsigned/1 stage, 2: unsigned/2 stages, 3: signed/1 stage
  localparam int SGN [4] = '{1, 0, 0, 1};
  localparam int STG [4] = '{2, 1, 2, 1};

  mult4_pp_compress_pipe #(.SIGNED(1), .STAGES(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_a(in_a[0]), .in_b(in_b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_row_a(row_a[0]), .out_row_b(row_b[0]), .out_c7(c7[0]));
  mult4_pp_compress_pipe #(.SIGNED(0), .STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_a(in_a[1]), .in_b(in_b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_row_a(row_a[1]), .out_row_b(row_b[1]), .out_c7(c7[1]));
  mult4_pp_compress_pipe #(.SIGNED(0), .STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_a(in_a[2]), .in_b(in_b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_row_a(row_a[2]), .out_row_b(row_b[2]), .out_c7(c7[2]));
  mult4_pp_compress_pipe #(.SIGNED(1), .STAGES(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
    .in_a(in_a[3]), .in_b(in_b[3]), .out_valid(out_valid[3]), .out_ready(out_ready[3]),
    .out_row_a(row_a[3]), .out_row_b(row_b[3]), .out_c7(c7[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] ref_prod(input int sgn, input logic [3:0] a, input logic [3:0] b);
    int x, y;
    x = int'(a);
    y = int'(b);
    if (sgn != 0) begin
      if (a[3]) x = x - 16;
      if (b[3]) y = y - 16;
    end
    return 8'(x * y);
  endfunction

  function automatic logic [7:0] recon(input logic [6:0] ra, input logic [6:0] rb, input logic c);
    logic [7:0] s;
    s = {1'b0, ra} + {1'b0, rb};
    return {s[7] ^ c, s[6:0]};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int idx, input logic v, input logic [3:0] a, input logic [3:0] b);
    in_valid[idx] = v;
    in_a[idx]     = a;
    in_b[idx]     = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = '1;
    for (int i = 0; i < 4; i++) begin
      in_a[i] = '0;
      in_b[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid[i] !== 1'b0 || row_a[i] !== 7'd0 || row_b[i] !== 7'd0 || c7[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: valid=%b a=%h b=%h c7=%b, required all 0",
                 i, out_valid[i], row_a[i], row_b[i], c7[i]);
      end
    end
    rst_n = 1'b1;
    next_cycle();
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready[i] !== 1'b1 || out_valid[i] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release dut%0d: in_ready=%b out_valid=%b, required 1/0",
                 i, in_ready[i], out_valid[i]);
      end
    end
  endtask

  task automatic test_signed_basic();
    drive(0, 1'b1, 4'h8, 4'h8);
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL basic_in_ready: got %b, required 1", in_ready[0]);
    end
    next_cycle();
    drive(0, 1'b0, 4'h0, 4'h0);
    #1;
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic_early_valid: out_valid=%b after 1 cycle, required 0", out_valid[0]);
    end
    next_cycle();
    #1;
    checks++;
    if (out_valid[0] !== 1'b1 || recon(row_a[0], row_b[0], c7[0]) !== 8'h40) begin
      errors++;
      $display("FAIL basic_m8xm8: valid=%b product=%h, required 1/40",
               out_valid[0], recon(row_a[0], row_b[0], c7[0]));
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [3:0] av [4];
    logic [3:0] bv [4];
    logic [7:0] ev [4];
    av = '{4'h7, 4'hF, 4'h5, 4'h0};
    bv = '{4'h8, 4'hF, 4'h3, 4'h9};
    ev = '{8'hC8, 8'h01, 8'h0F, 8'h00};
    for (int t = 0; t < 6; t++) begin
      if (t < 4) drive(0, 1'b1, av[t], bv[t]);
      else drive(0, 1'b0, 4'h0, 4'h0);
      #1;
      if (t >= 2) begin
        checks++;
        if (out_valid[0] !== 1'b1 || recon(row_a[0], row_b[0], c7[0]) !== ev[t-2]) begin
          errors++;
          $display("FAIL b2b_beat%0d: valid=%b product=%h, required 1/%h",
                   t - 2, out_valid[0], recon(row_a[0], row_b[0], c7[0]), ev[t-2]);
        end
      end
      next_cycle();
    end
    #1;
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: out_valid=%b, required 0", out_valid[0]);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] av [3];
    logic [3:0] bv [3];
    logic [6:0] ha, hb;
    logic       hc;
    for (int i = 0; i < 3; i++) begin
      av[i] = 4'($urandom_range(0, 15));
      bv[i] = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    out_ready[0] = 1'b0;
    drive(0, 1'b1, av[0], bv[0]);
    next_cycle();
    drive(0, 1'b1, av[1], bv[1]);
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_second_accept: in_ready=%b, required 1", in_ready[0]);
    end
    next_cycle();
    drive(0, 1'b1, av[2], bv[2]);
    #1;
    checks++;
    if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 ||
        recon(row_a[0], row_b[0], c7[0]) !== ref_prod(1, av[0], bv[0])) begin
      errors++;
      $display("FAIL bp_full: in_ready=%b valid=%b product=%h, required 0/1/%h", in_ready[0],
               out_valid[0], recon(row_a[0], row_b[0], c7[0]), ref_prod(1, av[0], bv[0]));
    end
    ha = row_a[0];
    hb = row_b[0];
    hc = c7[0];
    next_cycle();
    #1;
    checks++;
    if (in_ready[0] !== 1'b0 || out_valid[0] !== 1'b1 || row_a[0] !== ha ||
        row_b[0] !== hb || c7[0] !== hc) begin
      errors++;
      $display("FAIL bp_hold: in_ready=%b valid=%b rows=%h/%h/%b, required 0/1/%h/%h/%b",
               in_ready[0], out_valid[0], row_a[0], row_b[0], c7[0], ha, hb, hc);
    end
    next_cycle();
    out_ready[0] = 1'b1;
    #1;
    checks++;
    if (in_ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready=%b, required 1", in_ready[0]);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (out_valid[0] !== 1'b1 ||
          recon(row_a[0], row_b[0], c7[0]) !== ref_prod(1, av[k], bv[k])) begin
        errors++;
        $display("FAIL bp_drain%0d: valid=%b product=%h, required 1/%h", k, out_valid[0],
                 recon(row_a[0], row_b[0], c7[0]), ref_prod(1, av[k], bv[k]));
      end
      next_cycle();
      drive(0, 1'b0, 4'h0, 4'h0);
      #1;
    end
    checks++;
    if (out_valid[0] !== 1'b0) begin
      errors++;
      $display("FAIL bp_no_duplicate: out_valid=%b, required 0", out_valid[0]);
    end
    next_cycle();
  endtask

  task automatic test_unsigned_s1();
    drive(1, 1'b1, 4'd15, 4'd15);
    next_cycle();
    drive(1, 1'b1, 4'd9, 4'd14);
    #1;
    checks++;
    if (out_valid[1] !== 1'b1 || recon(row_a[1], row_b[1], c7[1]) !== 8'hE1) begin
      errors++;
      $display("FAIL u1_15x15: valid=%b product=%h, required 1/e1",
               out_valid[1], recon(row_a[1], row_b[1], c7[1]));
    end
    next_cycle();
    drive(1, 1'b0, 4'h0, 4'h0);
    #1;
    checks++;
    if (out_valid[1] !== 1'b1 || recon(row_a[1], row_b[1], c7[1]) !== 8'h7E) begin
      errors++;
      $display("FAIL u1_9x14: valid=%b product=%h, required 1/7e",
               out_valid[1], recon(row_a[1], row_b[1], c7[1]));
    end
    next_cycle();
    #1;
    checks++;
    if (out_valid[1] !== 1'b0) begin
      errors++;
      $display("FAIL u1_drain: out_valid=%b, required 0", out_valid[1]);
    end
  endtask

  task automatic test_reset_midflight();
    logic [3:0] a, b;
    @(negedge clk);
    out_ready[0] = 1'b0;
    drive(0, 1'b1, 4'h3, 4'h5);
    next_cycle();
    drive(0, 1'b1, 4'hA, 4'h6);
    next_cycle();
    drive(0, 1'b0, 4'h0, 4'h0);
    #1;
    checks++;
    if (out_valid[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_setup: out_valid=%b, required 1", out_valid[0]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || row_a[0] !== 7'd0 || row_b[0] !== 7'd0 || c7[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b rows=%h/%h/%b, required all 0",
               out_valid[0], row_a[0], row_b[0], c7[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    for (int t = 0; t < 3; t++) begin
      next_cycle();
      #1;
      checks++;
      if (out_valid[0] !== 1'b0) begin
        errors++;
        $display("FAIL midrst_stale%0d: out_valid=%b, required 0", t, out_valid[0]);
      end
    end
    next_cycle();
    a = 4'($urandom_range(0, 15));
    b = 4'($urandom_range(0, 15));
    drive(0, 1'b1, a, b);
    next_cycle();
    drive(0, 1'b0, 4'h0, 4'h0);
    next_cycle();
    #1;
    checks++;
    if (out_valid[0] !== 1'b1 || recon(row_a[0], row_b[0], c7[0]) !== ref_prod(1, a, b)) begin
      errors++;
      $display("FAIL midrst_after: valid=%b product=%h, required 1/%h",
               out_valid[0], recon(row_a[0], row_b[0], c7[0]), ref_prod(1, a, b));
    end
    next_cycle();
  endtask

  task automatic test_exhaustive(input int idx);
    logic [7:0] exp_q[$];
    logic [7:0] kv, got, exp_p;
    int         k, cycles;
    logic       offered, pv, pr, pc;
    logic [6:0] pa, pb;
    k = 0;
    cycles = 0;
    offered = 1'b0;
    pv = 1'b0;
    pr = 1'b0;
    pa = '0;
    pb = '0;
    pc = 1'b0;
    @(negedge clk);
    while ((k < 256 || exp_q.size() > 0) && cycles < 4000) begin
      out_ready[idx] = ($urandom_range(0, 3) != 0);
      if (!offered) begin
        if (k < 256 && $urandom_range(0, 3) != 0) begin
          kv = k[7:0];
          drive(idx, 1'b1, kv[7:4], kv[3:0]);
          offered = 1'b1;
        end else begin
          drive(idx, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end
      end
      #1;
      if (pv && !pr) begin
        checks++;
        if (out_valid[idx] !== 1'b1 || row_a[idx] !== pa || row_b[idx] !== pb || c7[idx] !== pc) begin
          errors++;
          $display("FAIL exh%0d_stall_hold: valid=%b rows=%h/%h/%b, required 1/%h/%h/%b",
                   idx, out_valid[idx], row_a[idx], row_b[idx], c7[idx], pa, pb, pc);
        end
      end
      if (in_valid[idx] && in_ready[idx]) begin
        exp_q.push_back(ref_prod(SGN[idx], in_a[idx], in_b[idx]));
        k++;
        offered = 1'b0;
      end
      if (out_valid[idx] && out_ready[idx]) begin
        got = recon(row_a[idx], row_b[idx], c7[idx]);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL exh%0d_extra_beat: product=%h, required no beat", idx, got);
        end else begin
          exp_p = exp_q.pop_front();
          if (got !== exp_p) begin
            errors++;
            $display("FAIL exh%0d_product: got %h, required %h", idx, got, exp_p);
          end
        end
      end
      pv = out_valid[idx];
      pr = out_ready[idx];
      pa = row_a[idx];
      pb = row_b[idx];
      pc = c7[idx];
      next_cycle();
      cycles++;
    end
    drive(idx, 1'b0, 4'h0, 4'h0);
    out_ready[idx] = 1'b1;
    checks++;
    if (k != 256 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL exh%0d_complete: accepted=%0d pending=%0d, required 256/0",
               idx, k, exp_q.size());
    end
    next_cycle();
    #1;
    checks++;
    if (out_valid[idx] !== 1'b0) begin
      errors++;
      $display("FAIL exh%0d_empty: out_valid=%b, required 0", idx, out_valid[idx]);
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_back_to_back();
    test_backpressure();
    test_unsigned_s1();
    test_reset_midflight();
    for (int i = 0; i < 4; i++) test_exhaustive(i);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
